// File: rtl/risc_v_32_i_pkg.sv
// risc_v_32_i_pkg: shared types and constants for the data-memory arbiter
package risc_v_32_i_pkg;
  typedef enum logic {ARB_IDLE, ARB_WAIT_RSP} arb_state_e;
  typedef enum logic {ARB_OWNER_CORE, ARB_OWNER_LOADER} arb_owner_e;
  localparam int DMEM_ARB_MASTERS = 2;
endpackage

// File: rtl/dmem_arb_picker.sv
// dmem_arb_picker: winner select; DMEM_ARBITER_ROUND_ROBIN_EN selects round-robin over fixed priority
module dmem_arb_picker
  import risc_v_32_i_pkg::*;
(
  input  logic [DMEM_ARB_MASTERS-1:0] req_i,
  input  logic                        last_i,
  output logic                        winner_o
);
`ifdef DMEM_ARBITER_ROUND_ROBIN_EN
  // on a tie the master that did not win last time goes first
  always_comb winner_o = &req_i ? ~last_i : req_i[1];
`else
  logic unused_last;
  assign unused_last = last_i;
  // core wins any tie; loader only wins when it requests alone
  always_comb winner_o = req_i[1] & ~req_i[0];
`endif
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-master data-memory port arbiter with response routing and timeout abort (DMEM_ARBITER_ROUND_ROBIN_EN)
module dmem_arbiter
  import risc_v_32_i_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TMO_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                                 clk_i,
  input  logic                                 reset_i,
  input  logic [DMEM_ARB_MASTERS-1:0]          m_req_i,
  input  logic [DMEM_ARB_MASTERS-1:0]          m_we_i,
  input  logic [DMEM_ARB_MASTERS*XLEN-1:0]     m_addr_i,
  input  logic [DMEM_ARB_MASTERS*XLEN-1:0]     m_wdata_i,
  input  logic [DMEM_ARB_MASTERS*4-1:0]        m_strobe_i,
  output logic [DMEM_ARB_MASTERS-1:0]          m_gnt_o,
  output logic [DMEM_ARB_MASTERS-1:0]          m_rvalid_o,
  output logic [XLEN-1:0]                      m_rdata_o,
  output logic                                 m_err_o,
  output logic                                 s_req_o,
  output logic                                 s_we_o,
  output logic [XLEN-1:0]                      s_addr_o,
  output logic [XLEN-1:0]                      s_wdata_o,
  output logic [3:0]                           s_strobe_o,
  input  logic                                 s_gnt_i,
  input  logic                                 s_rvalid_i,
  input  logic [XLEN-1:0]                      s_rdata_i
);
  arb_state_e       state_q, state_d;
  arb_owner_e       owner_q, owner_d;
  logic [TMO_W-1:0] cnt_q, cnt_d;
  logic             last_q, last_d;
  logic             winner;
  logic [1:0]       owner_oh;

  dmem_arb_picker u_picker (
    .req_i   (m_req_i),
    .last_i  (last_q),
    .winner_o(winner)
  );

  assign owner_oh = owner_q == ARB_OWNER_LOADER ? 2'b10 : 2'b01;

  // next state and outputs; everything is forced low while reset is asserted
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    m_gnt_o    = '0;
    m_rvalid_o = '0;
    m_rdata_o  = '0;
    m_err_o    = 1'b0;
    s_req_o    = 1'b0;
    s_we_o     = 1'b0;
    s_addr_o   = '0;
    s_wdata_o  = '0;
    s_strobe_o = '0;
    if (!reset_i && state_q == ARB_IDLE && |m_req_i) begin
      s_req_o    = 1'b1;
      s_we_o     = m_we_i[winner];
      s_addr_o   = winner ? m_addr_i[2*XLEN-1:XLEN] : m_addr_i[XLEN-1:0];
      s_wdata_o  = winner ? m_wdata_i[2*XLEN-1:XLEN] : m_wdata_i[XLEN-1:0];
      s_strobe_o = winner ? m_strobe_i[7:4] : m_strobe_i[3:0];
      if (s_gnt_i) begin
        m_gnt_o[winner] = 1'b1;
        owner_d         = arb_owner_e'(winner);
        last_d          = winner;
        cnt_d           = '0;
        state_d         = ARB_WAIT_RSP;
      end
    end else if (!reset_i && state_q == ARB_WAIT_RSP) begin
      if (s_rvalid_i) begin
        m_rvalid_o = owner_oh;
        m_rdata_o  = s_rdata_i;
        state_d    = ARB_IDLE;
      end else if (cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
        m_rvalid_o = owner_oh;
        m_err_o    = 1'b1;
        state_d    = ARB_IDLE;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // state registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ARB_IDLE;
      owner_q <= ARB_OWNER_CORE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scenario tasks with a response scoreboard for dmem_arbiter
module tb_dmem_arbiter;
  typedef struct packed {
    logic [1:0]  rv;
    logic [31:0] data;
    logic        err;
  } rsp_t;

  logic        clk = 1'b0;
  logic        reset_i;
  logic [1:0]  m_req_i, m_we_i;
  logic [63:0] m_addr_i, m_wdata_i;
  logic [7:0]  m_strobe_i;
  logic [1:0]  m_gnt_o, m_rvalid_o;
  logic [31:0] m_rdata_o;
  logic        m_err_o;
  logic        s_req_o, s_we_o;
  logic [31:0] s_addr_o, s_wdata_o;
  logic [3:0]  s_strobe_o;
  logic        s_gnt_i, s_rvalid_i;
  logic [31:0] s_rdata_i;

  int   checks = 0;
  int   failures = 0;
  rsp_t sb[$];

  always #5 clk = ~clk;

  dmem_arbiter #(.XLEN(32), .TIMEOUT_CYCLES(16)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .m_req_i(m_req_i), .m_we_i(m_we_i), .m_addr_i(m_addr_i), .m_wdata_i(m_wdata_i),
    .m_strobe_i(m_strobe_i), .m_gnt_o(m_gnt_o), .m_rvalid_o(m_rvalid_o),
    .m_rdata_o(m_rdata_o), .m_err_o(m_err_o), .s_req_o(s_req_o), .s_we_o(s_we_o),
    .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o), .s_strobe_o(s_strobe_o),
    .s_gnt_i(s_gnt_i), .s_rvalid_i(s_rvalid_i), .s_rdata_i(s_rdata_i)
  );

  task automatic idle_inputs;
    m_req_i = '0; m_we_i = '0; m_addr_i = '0; m_wdata_i = '0; m_strobe_i = '0;
    s_gnt_i = 1'b0; s_rvalid_i = 1'b0; s_rdata_i = '0;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      reset_i = 1'b1; m_req_i = 2'b11; m_we_i = 2'b11; m_addr_i = {32'h8, 32'h4};
      m_wdata_i = {32'h22, 32'h11}; m_strobe_i = 8'hFF;
      s_gnt_i = 1'b1; s_rvalid_i = 1'b1; s_rdata_i = 32'h1234;
      #1 checks++;
      if ({m_gnt_o, m_rvalid_o, m_rdata_o, m_err_o, s_req_o, s_we_o, s_addr_o, s_wdata_o, s_strobe_o} !== '0) begin
        failures++;
        $display("FAIL reset_outputs gnt=%b rv=%b rdata=%h err=%b sreq=%b saddr=%h, required all zero",
                 m_gnt_o, m_rvalid_o, m_rdata_o, m_err_o, s_req_o, s_addr_o);
      end
    end
    @(negedge clk);
    reset_i = 1'b0; idle_inputs(); s_rvalid_i = 1'b1; s_rdata_i = 32'h5555;
    #1 checks++;
    if ({m_rvalid_o, s_req_o, m_gnt_o} !== '0) begin
      failures++;
      $display("FAIL stray_after_reset rv=%b sreq=%b gnt=%b, required 0", m_rvalid_o, s_req_o, m_gnt_o);
    end
  endtask

  task automatic test_core_read;
    rsp_t e;
    @(negedge clk);
    idle_inputs(); m_req_i = 2'b01; m_addr_i = {32'h0, 32'h80}; s_gnt_i = 1'b1;
    #1 checks++;
    if ({m_gnt_o, s_req_o, s_we_o, s_addr_o} !== {2'b01, 1'b1, 1'b0, 32'h80}) begin
      failures++;
      $display("FAIL core_read_gnt gnt=%b sreq=%b we=%b addr=%h, required 01 1 0 00000080", m_gnt_o, s_req_o, s_we_o, s_addr_o);
    end
    sb.push_back('{2'b01, 32'hDEADBEEF, 1'b0});
    @(negedge clk);
    m_req_i = 2'b00; s_gnt_i = 1'b0; s_rvalid_i = 1'b1; s_rdata_i = 32'hDEADBEEF;
    #1 checks++;
    if ({s_req_o, m_gnt_o} !== 3'b000) begin
      failures++;
      $display("FAIL core_read_nosreq sreq=%b gnt=%b, required 0 00", s_req_o, m_gnt_o);
    end
    checks++;
    if (m_rvalid_o === 2'b00 || sb.size() == 0) begin
      failures++;
      $display("FAIL core_read_rsp rv=%b, required a response", m_rvalid_o);
    end else begin
      e = sb.pop_front();
      if ({m_rvalid_o, m_rdata_o, m_err_o} !== e) begin
        failures++;
        $display("FAIL core_read_rsp got rv=%b data=%h err=%b required rv=%b data=%h err=%b",
                 m_rvalid_o, m_rdata_o, m_err_o, e.rv, e.data, e.err);
      end
    end
  endtask

  task automatic test_back_to_back;
    rsp_t e;
    logic last, w;
    @(negedge clk); idle_inputs(); reset_i = 1'b1;
    @(negedge clk); reset_i = 1'b0;
    last = 1'b1;
    for (int i = 0; i < 4; i++) begin
`ifdef DMEM_ARBITER_ROUND_ROBIN_EN
      w = ~last;
`else
      w = 1'b0;
`endif
      last = w;
      @(negedge clk);
      m_req_i = 2'b11; m_addr_i = {32'h2000 + 32'(i), 32'h1000 + 32'(i)};
      s_gnt_i = 1'b1; s_rvalid_i = 1'b0;
      #1 checks++;
      if ({m_gnt_o, s_addr_o} !== {(w ? 2'b10 : 2'b01), (w ? 32'h2000 : 32'h1000) + 32'(i)}) begin
        failures++;
        $display("FAIL b2b_gnt%0d gnt=%b addr=%h, required winner %0d", i, m_gnt_o, s_addr_o, w);
      end
      sb.push_back('{(w ? 2'b10 : 2'b01), 32'hA500_0000 + 32'(i), 1'b0});
      @(negedge clk);
      s_rvalid_i = 1'b1; s_rdata_i = 32'hA500_0000 + 32'(i);
      #1 checks++;
      if ({s_req_o, m_gnt_o} !== 3'b000) begin
        failures++;
        $display("FAIL b2b_hold%0d sreq=%b gnt=%b, required 0 00", i, s_req_o, m_gnt_o);
      end
      checks++;
      if (m_rvalid_o === 2'b00 || sb.size() == 0) begin
        failures++;
        $display("FAIL b2b_rsp%0d rv=%b, required a response", i, m_rvalid_o);
      end else begin
        e = sb.pop_front();
        if ({m_rvalid_o, m_rdata_o, m_err_o} !== e) begin
          failures++;
          $display("FAIL b2b_rsp%0d got rv=%b data=%h err=%b required rv=%b data=%h err=%b",
                   i, m_rvalid_o, m_rdata_o, m_err_o, e.rv, e.data, e.err);
        end
      end
    end
  endtask

  task automatic test_stall;
    rsp_t e;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      idle_inputs(); m_req_i = 2'b10; m_we_i = 2'b10;
      m_addr_i = {32'h100, 32'h44}; m_wdata_i = {32'h5566_7788, 32'h1}; m_strobe_i = 8'b0011_1111;
      s_gnt_i = (i == 3);
      #1 checks++;
      if ({s_req_o, s_we_o, s_addr_o, s_wdata_o, s_strobe_o} !== {1'b1, 1'b1, 32'h100, 32'h5566_7788, 4'b0011}) begin
        failures++;
        $display("FAIL stall_payload%0d sreq=%b we=%b addr=%h wdata=%h strb=%b, required 1 1 00000100 55667788 0011",
                 i, s_req_o, s_we_o, s_addr_o, s_wdata_o, s_strobe_o);
      end
      checks++;
      if (m_gnt_o !== (i == 3 ? 2'b10 : 2'b00)) begin
        failures++;
        $display("FAIL stall_gnt%0d gnt=%b, required %b", i, m_gnt_o, (i == 3 ? 2'b10 : 2'b00));
      end
    end
    sb.push_back('{2'b10, 32'h0, 1'b0});
    @(negedge clk);
    idle_inputs(); s_rvalid_i = 1'b1;
    #1 checks++;
    if (m_rvalid_o === 2'b00 || sb.size() == 0) begin
      failures++;
      $display("FAIL stall_rsp rv=%b, required a response", m_rvalid_o);
    end else begin
      e = sb.pop_front();
      if ({m_rvalid_o, m_rdata_o, m_err_o} !== e) begin
        failures++;
        $display("FAIL stall_rsp got rv=%b data=%h err=%b required rv=%b data=%h err=%b",
                 m_rvalid_o, m_rdata_o, m_err_o, e.rv, e.data, e.err);
      end
    end
  endtask

  task automatic test_timeout;
    rsp_t e;
    int   n;
    @(negedge clk);
    idle_inputs(); m_req_i = 2'b01; m_addr_i = {32'h0, 32'h40}; s_gnt_i = 1'b1;
    #1 checks++;
    if (m_gnt_o !== 2'b01) begin
      failures++;
      $display("FAIL tmo_gnt gnt=%b, required 01", m_gnt_o);
    end
    sb.push_back('{2'b01, 32'h0, 1'b1});
    n = 21;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      idle_inputs(); s_rdata_i = 32'hFFFF_FFFF;
      #1 if (m_rvalid_o !== 2'b00) begin
        n = k;
        break;
      end
    end
    checks++;
    if (n != 16) begin
      failures++;
      $display("FAIL tmo_latency got %0d cycles after grant, required 16", n);
    end
    checks++;
    if (n > 20 || sb.size() == 0) begin
      failures++;
      $display("FAIL tmo_rsp no abort response, required rv=01 err=1");
    end else begin
      e = sb.pop_front();
      if ({m_rvalid_o, m_rdata_o, m_err_o} !== e) begin
        failures++;
        $display("FAIL tmo_rsp got rv=%b data=%h err=%b required rv=%b data=%h err=%b",
                 m_rvalid_o, m_rdata_o, m_err_o, e.rv, e.data, e.err);
      end
    end
    @(negedge clk); idle_inputs();
    @(negedge clk); s_rvalid_i = 1'b1; s_rdata_i = 32'h7777;
    #1 checks++;
    if ({m_rvalid_o, m_err_o} !== 3'b000) begin
      failures++;
      $display("FAIL tmo_late_ignored rv=%b err=%b, required 00 0", m_rvalid_o, m_err_o);
    end
  endtask

  task automatic test_expiry_rvalid;
    rsp_t e;
    int   early;
    @(negedge clk);
    idle_inputs(); m_req_i = 2'b10; m_addr_i = {32'h60, 32'h0}; s_gnt_i = 1'b1;
    #1 checks++;
    if (m_gnt_o !== 2'b10) begin
      failures++;
      $display("FAIL exp_gnt gnt=%b, required 10", m_gnt_o);
    end
    sb.push_back('{2'b10, 32'hCAFE_F00D, 1'b0});
    early = 0;
    for (int k = 1; k < 16; k++) begin
      @(negedge clk);
      idle_inputs();
      #1 if (m_rvalid_o !== 2'b00) early++;
    end
    checks++;
    if (early != 0) begin
      failures++;
      $display("FAIL exp_early got %0d early responses, required 0", early);
    end
    @(negedge clk);
    s_rvalid_i = 1'b1; s_rdata_i = 32'hCAFE_F00D;
    #1 checks++;
    if (m_rvalid_o === 2'b00 || sb.size() == 0) begin
      failures++;
      $display("FAIL exp_rsp rv=%b, required a response", m_rvalid_o);
    end else begin
      e = sb.pop_front();
      if ({m_rvalid_o, m_rdata_o, m_err_o} !== e) begin
        failures++;
        $display("FAIL exp_rsp got rv=%b data=%h err=%b required rv=%b data=%h err=%b",
                 m_rvalid_o, m_rdata_o, m_err_o, e.rv, e.data, e.err);
      end
    end
  endtask

  task automatic test_reset_mid;
    rsp_t e;
    @(negedge clk);
    idle_inputs(); m_req_i = 2'b01; m_addr_i = {32'h0, 32'h90}; s_gnt_i = 1'b1;
    #1 checks++;
    if (m_gnt_o !== 2'b01) begin
      failures++;
      $display("FAIL rmid_gnt gnt=%b, required 01", m_gnt_o);
    end
    @(negedge clk); idle_inputs();
    @(negedge clk);
    reset_i = 1'b1; s_rvalid_i = 1'b1; s_rdata_i = 32'hBAD0_BAD0; m_req_i = 2'b01; s_gnt_i = 1'b1;
    #1 checks++;
    if ({m_gnt_o, m_rvalid_o, m_rdata_o, m_err_o, s_req_o, s_addr_o} !== '0) begin
      failures++;
      $display("FAIL rmid_outputs gnt=%b rv=%b rdata=%h sreq=%b, required all zero", m_gnt_o, m_rvalid_o, m_rdata_o, s_req_o);
    end
    @(negedge clk);
    reset_i = 1'b0; idle_inputs(); s_rvalid_i = 1'b1; s_rdata_i = 32'hBAD0_BAD0;
    #1 checks++;
    if (m_rvalid_o !== 2'b00) begin
      failures++;
      $display("FAIL rmid_no_rsp rv=%b, required 00", m_rvalid_o);
    end
    @(negedge clk);
    idle_inputs(); m_req_i = 2'b01; m_addr_i = {32'h0, 32'h94}; s_gnt_i = 1'b1;
    #1 checks++;
    if ({m_gnt_o, s_addr_o} !== {2'b01, 32'h94}) begin
      failures++;
      $display("FAIL rmid_regnt gnt=%b addr=%h, required 01 00000094", m_gnt_o, s_addr_o);
    end
    sb.push_back('{2'b01, 32'h0BAD_CAFE, 1'b0});
    @(negedge clk);
    idle_inputs(); s_rvalid_i = 1'b1; s_rdata_i = 32'h0BAD_CAFE;
    #1 checks++;
    if (m_rvalid_o === 2'b00 || sb.size() == 0) begin
      failures++;
      $display("FAIL rmid_rsp rv=%b, required a response", m_rvalid_o);
    end else begin
      e = sb.pop_front();
      if ({m_rvalid_o, m_rdata_o, m_err_o} !== e) begin
        failures++;
        $display("FAIL rmid_rsp got rv=%b data=%h err=%b required rv=%b data=%h err=%b",
                 m_rvalid_o, m_rdata_o, m_err_o, e.rv, e.data, e.err);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset_i = 1'b1;
    idle_inputs();
    test_reset();
    test_core_read();
    test_back_to_back();
    test_stall();
    test_timeout();
    test_expiry_rvalid();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain %0d responses outstanding, required 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
